// File: rtl/xm_mem_pkg.sv
// X-Makina memory responder: shared FSM states, byte-lane masks
// and the request address check.
package xm_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        CAPTURE,
        RESP
    } xm_state_e;

    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    // Word accesses must be even; every byte must lie inside the RAM.
    function automatic logic mem_addr_ok(
        input logic [31:0] addr,
        input logic        is_byte,
        input int unsigned depth
    );
        if (!is_byte && addr[0]) return 1'b0;
        return addr < 32'(2 * depth);
    endfunction

endpackage

// File: rtl/xm_mem_responder_if.sv
// Processor-side request bus and RAM-side port bundles for the
// X-Makina memory responder.
interface xm_mem_req_if #(
    parameter int WORD = 16
);
    logic            req_i;
    logic            wr_i;
    logic            byte_i;
    logic [WORD-1:0] addr_i;
    logic [WORD-1:0] wdata_i;
    logic            ack_o;
    logic            err_o;
    logic [WORD-1:0] rdata_o;

    modport master (
        output req_i, wr_i, byte_i, addr_i, wdata_i,
        input  ack_o, err_o, rdata_o
    );
    modport slave (
        input  req_i, wr_i, byte_i, addr_i, wdata_i,
        output ack_o, err_o, rdata_o
    );
endinterface

interface xm_mem_ram_if #(
    parameter int WORD = 16,
    parameter int AW   = 10
);
    logic            ram_en_o;
    logic [1:0]      ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [WORD-1:0] ram_wdata_o;
    logic [WORD-1:0] ram_rdata_i;

    modport master (
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );
    modport slave (
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/xm_byte_lane.sv
// Byte-lane steering: write replication and enables, or read-lane
// extraction with zero extension, selected by READ.
module xm_byte_lane
    import xm_mem_pkg::*;
#(
    parameter int WORD = 16,
    parameter bit READ = 1'b0
) (
    input  logic            is_byte,
    input  logic            lsb,
    input  logic [WORD-1:0] din,
    output logic [WORD-1:0] dout,
    output logic [1:0]      we
);

    logic [1:0] lanes;

    always_comb begin
        lanes = LANE_BOTH;
        if (is_byte) lanes = lsb ? LANE_HI : LANE_LO;
    end

    if (READ) begin : g_rd
        assign we = 2'b00;
        always_comb begin
            dout = din;
            unique case (1'b1)
                lanes == LANE_HI: dout = WORD'(din[15:8]);
                lanes == LANE_LO: dout = WORD'(din[7:0]);
                default:          dout = din;
            endcase
        end
    end else begin : g_wr
        // A byte goes out on both lanes; the enables pick the target.
        assign we   = lanes;
        assign dout = is_byte ? {(WORD/8){din[7:0]}} : din;
    end

endmodule

// File: rtl/xm_mem_responder.sv
// X-Makina memory responder: checks, waits, steers one access to a
// synchronous word RAM and acknowledges it with a one-cycle pulse.
module xm_mem_responder
    import xm_mem_pkg::*;
#(
    parameter int WORD        = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    xm_mem_req_if.slave  req_if,
    xm_mem_ram_if.master ram_if
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    xm_state_e       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            take;
    logic            addr_ok;
    logic            wr_q, byte_q;
    logic [AW:0]     addr_q;
    logic [WORD-1:0] wdata_q;
    logic            cur_wr, cur_byte;
    logic [AW:0]     cur_addr;
    logic [WORD-1:0] cur_wdata;
    logic [WORD-1:0] wr_data, rd_data;
    logic [1:0]      wr_we, rd_we;

    assign take    = (state_q == IDLE) && req_if.req_i;
    assign addr_ok = mem_addr_ok(32'(req_if.addr_i), req_if.byte_i,
                                 MEM_WORDS);

    // With no wait states ACCESS follows IDLE, so steer from the bus.
    assign cur_wr    = take ? req_if.wr_i          : wr_q;
    assign cur_byte  = take ? req_if.byte_i        : byte_q;
    assign cur_addr  = take ? req_if.addr_i[AW:0]  : addr_q;
    assign cur_wdata = take ? req_if.wdata_i       : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (!addr_ok) begin
                        state_d = RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    xm_byte_lane #(.WORD(WORD), .READ(1'b0)) u_wr_lane (
        .is_byte (cur_byte),
        .lsb     (cur_addr[0]),
        .din     (cur_wdata),
        .dout    (wr_data),
        .we      (wr_we)
    );

    xm_byte_lane #(.WORD(WORD), .READ(1'b1)) u_rd_lane (
        .is_byte (byte_q),
        .lsb     (addr_q[0]),
        .din     (ram_if.ram_rdata_i),
        .dout    (rd_data),
        .we      (rd_we)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                wr_q    <= req_if.wr_i;
                byte_q  <= req_if.byte_i;
                addr_q  <= req_if.addr_i[AW:0];
                wdata_q <= req_if.wdata_i;
            end
        end
    end

    // Only the error path goes straight from IDLE to RESP.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            req_if.ack_o   <= 1'b0;
            req_if.err_o   <= 1'b0;
            req_if.rdata_o <= '0;
        end else begin
            req_if.ack_o <= (state_d == RESP);
            req_if.err_o <= (state_d == RESP) && take;
            if (state_q == CAPTURE && !wr_q) req_if.rdata_o <= rd_data;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ram_if.ram_en_o    <= 1'b0;
            ram_if.ram_we_o    <= '0;
            ram_if.ram_addr_o  <= '0;
            ram_if.ram_wdata_o <= '0;
        end else begin
            ram_if.ram_en_o <= (state_d == ACCESS);
            ram_if.ram_we_o <= '0;
            if (state_d == ACCESS) begin
                ram_if.ram_we_o   <= cur_wr ? wr_we : rd_we;
                ram_if.ram_addr_o <= cur_addr[AW:1];
                if (cur_wr) ram_if.ram_wdata_o <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_xm_mem_responder.sv
// Scoreboard bench for xm_mem_responder at 1, 0 and 3 wait states
// against a byte-addressed memory model.
module tb_xm_mem_responder;

    localparam int N     = 3;
    localparam int DEPTH = 1024;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    typedef struct {
        logic        err;
        logic        chk_data;
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [1:0]  we;
        logic [9:0]  a;
        logic        chk_wd;
        logic [15:0] wd;
    } ram_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, wr, by, ack, ram_en, clean;
    logic [15:0]   addr_v  [N];
    logic [15:0]   wdata_v [N];
    logic [7:0]    bmem    [N][2*DEPTH];
    rsp_t          rsp_q   [N][$];
    ram_t          ram_q   [N][$];
    int            cyc = 0;
    int            cmp = 0;
    int            bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int k, input string nm,
                         input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0d: got %h want %h",
                     nm, k, cyc, act, exp);
        end
    endtask

    for (genvar i = 0; i < N; i++) begin : g
        xm_mem_req_if #(.WORD(16)) rif ();
        xm_mem_ram_if #(.WORD(16), .AW(10)) ram ();
        logic [15:0] mem [DEPTH] = '{default: 16'h0000};

        assign rif.req_i   = req[i];
        assign rif.wr_i    = wr[i];
        assign rif.byte_i  = by[i];
        assign rif.addr_i  = addr_v[i];
        assign rif.wdata_i = wdata_v[i];
        assign ack[i]      = rif.ack_o;
        assign ram_en[i]   = ram.ram_en_o;
        assign clean[i]    = !rif.ack_o && !rif.err_o &&
                             rif.rdata_o == 16'h0 && !ram.ram_en_o &&
                             ram.ram_we_o == 2'b00 &&
                             ram.ram_addr_o == 10'h0 &&
                             ram.ram_wdata_o == 16'h0;

        xm_mem_responder #(
            .WORD        (16),
            .MEM_WORDS   (DEPTH),
            .WAIT_STATES (ws_of(i))
        ) dut (
            .clk_i   (clk),
            .arst_ni (rst_n),
            .req_if  (rif),
            .ram_if  (ram)
        );

        always @(posedge clk) begin
            if (ram.ram_en_o) begin
                if (ram.ram_we_o[0])
                    mem[ram.ram_addr_o][7:0] <= ram.ram_wdata_o[7:0];
                if (ram.ram_we_o[1])
                    mem[ram.ram_addr_o][15:8] <= ram.ram_wdata_o[15:8];
                ram.ram_rdata_i <= mem[ram.ram_addr_o];
            end
        end

        always @(posedge clk) begin
            rsp_t e;
            ram_t r;
            #1;
            if (rif.ack_o) begin
                if (rsp_q[i].size() == 0) begin
                    cmp++;
                    bad++;
                    $display("FAIL unexpected_ack dut%0d @%0d: got 1 want 0",
                             i, cyc);
                end else begin
                    e = rsp_q[i].pop_front();
                    check(i, "ack_cycle", 32'(cyc), 32'(e.cyc));
                    check(i, "err", 32'(rif.err_o), 32'(e.err));
                    if (e.chk_data)
                        check(i, "rdata", 32'(rif.rdata_o), 32'(e.data));
                end
            end else begin
                check(i, "err_idle", 32'(rif.err_o), 32'(0));
            end
            if (ram.ram_en_o) begin
                if (ram_q[i].size() == 0) begin
                    cmp++;
                    bad++;
                    $display("FAIL unexpected_ram_en dut%0d @%0d: got 1 want 0",
                             i, cyc);
                end else begin
                    r = ram_q[i].pop_front();
                    check(i, "ram_we", 32'(ram.ram_we_o), 32'(r.we));
                    check(i, "ram_addr", 32'(ram.ram_addr_o), 32'(r.a));
                    if (r.chk_wd)
                        check(i, "ram_wdata", 32'(ram.ram_wdata_o), 32'(r.wd));
                end
            end
        end
    end

    task automatic issue(input int k, input bit w, input bit b,
                         input logic [15:0] a, input logic [15:0] d,
                         input bit hold);
        bit   e;
        int   wi, n;
        rsp_t x;
        ram_t r;
        @(negedge clk);
        wr[k] = w;
        by[k] = b;
        addr_v[k] = a;
        wdata_v[k] = d;
        req[k] = 1'b1;
        e = (!b && a[0]) || (int'(a) >= 2 * DEPTH);
        x.err = e;
        x.chk_data = !e && !w;
        x.data = 16'h0;
        x.cyc = cyc + 1 + (e ? 0 : ws_of(k) + 2);
        if (!e) begin
            wi = int'(a) / 2;
            r.a = 10'(wi);
            r.chk_wd = w;
            r.wd = b ? {d[7:0], d[7:0]} : d;
            r.we = !w ? 2'b00 : !b ? 2'b11 : a[0] ? 2'b10 : 2'b01;
            if (w) begin
                bmem[k][int'(a)] = d[7:0];
                if (!b) bmem[k][int'(a) + 1] = d[15:8];
            end else if (b) begin
                x.data = {8'h00, bmem[k][int'(a)]};
            end else begin
                x.data = {bmem[k][int'(a) + 1], bmem[k][int'(a)]};
            end
            ram_q[k].push_back(r);
        end
        rsp_q[k].push_back(x);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                wr[k] = 1'($urandom);
                by[k] = 1'($urandom);
                addr_v[k] = 16'($urandom);
                wdata_v[k] = 16'($urandom);
            end
        end while (!ack[k] && n < 40);
        if (!ack[k]) begin
            cmp++;
            bad++;
            $display("FAIL ack_timeout dut%0d addr %h: got 0 want 1", k, a);
        end
        if (!hold) req[k] = 1'b0;
        @(posedge clk);
    endtask

    task automatic reset_mid(input int k);
        ram_t r;
        @(negedge clk);
        wr[k] = 1'b1;
        by[k] = 1'b0;
        addr_v[k] = 16'h0010;
        wdata_v[k] = 16'hDEAD;
        req[k] = 1'b1;
        r.we = 2'b11;
        r.a = 10'd8;
        r.chk_wd = 1'b1;
        r.wd = 16'hDEAD;
        ram_q[k].push_back(r);
        @(posedge clk);
        repeat (ws_of(k)) @(posedge clk);
        #1;
        check(k, "en_in_access", 32'(ram_en[k]), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check(k, "en_after_reset", 32'(ram_en[k]), 32'(0));
        check(k, "ack_after_reset", 32'(ack[k]), 32'(0));
        req[k] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          rw, rb, rh, hp;
        logic [15:0] ra, rd;
        rst_n = 1'b0;
        req = '0;
        wr = '0;
        by = '0;
        for (int k = 0; k < N; k++) begin
            addr_v[k] = 16'h0;
            wdata_v[k] = 16'h0;
            for (int j = 0; j < 2 * DEPTH; j++) bmem[k][j] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++)
            check(k, "reset_state", 32'(clean[k]), 32'(1));
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) begin
            issue(k, 1, 0, 16'h0010, 16'hBEEF, 0);
            issue(k, 0, 0, 16'h0010, 16'h0000, 0);
            issue(k, 1, 0, 16'h0020, 16'h1234, 0);
            issue(k, 1, 1, 16'h0021, 16'h00AB, 0);
            issue(k, 0, 1, 16'h0021, 16'h0000, 0);
            issue(k, 0, 0, 16'h0020, 16'h0000, 0);
            issue(k, 0, 0, 16'h0003, 16'h0000, 0);
            issue(k, 0, 1, 16'h0800, 16'h0000, 0);
            issue(k, 0, 1, 16'h07FF, 16'h0000, 0);
            issue(k, 0, 0, 16'hFFFF, 16'h0000, 0);
            issue(k, 1, 0, 16'h07FE, 16'h5A5A, 0);
            issue(k, 0, 0, 16'h07FE, 16'h0000, 0);
            issue(k, 1, 1, 16'h0800, 16'h0011, 0);
            issue(k, 1, 0, 16'h0000, 16'hC0DE, 0);
            issue(k, 1, 0, 16'h0002, 16'hF00D, 0);
            issue(k, 0, 0, 16'h0000, 16'h0000, 1);
            issue(k, 0, 0, 16'h0002, 16'h0000, 0);
            reset_mid(k);
            issue(k, 0, 0, 16'h0010, 16'h0000, 0);
            hp = 1'b0;
            for (int j = 0; j < 60; j++) begin
                if (!hp) repeat ($urandom_range(0, 2)) @(posedge clk);
                rw = 1'($urandom);
                rb = 1'($urandom);
                rh = ($urandom_range(0, 3) == 0) && (j < 59);
                rd = 16'($urandom);
                if ($urandom_range(0, 7) == 0)
                    ra = 16'($urandom_range(2 * DEPTH - 4, 65535));
                else
                    ra = 16'($urandom_range(0, 63));
                issue(k, rw, rb, ra, rd, rh);
                hp = rh;
            end
        end

        repeat (10) @(posedge clk);
        for (int k = 0; k < N; k++) begin
            check(k, "rsp_left", 32'(rsp_q[k].size()), 32'(0));
            check(k, "ram_left", 32'(ram_q[k].size()), 32'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
